// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths, the arbiter state encoding
// and the watchdog counter width helper used by the transfer arbiter.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } arb_state_e;

   // The watchdog only has to count up to cycles-2, so clog2(cycles) bits suffice.
   function automatic int timeout_w(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set req bit after last_grant,
// wrapping modulo N. Returns a one-hot winner and a valid flag.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last_grant,
   output logic [N-1:0] gnt,
   output logic         valid
);

   // Walk the ring starting just past last_grant; each index is visited once.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int off = 1; off <= N; off++) begin
         int   idx;
         logic take;
         idx      = (int'(last_grant) + off) % N;
         take     = req[idx] & ~valid;
         gnt[idx] = take;
         valid    = valid | take;
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C byte-write engine between NUM_REQ clients.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with an err pulse.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic                         err,
   output logic                         busy,
   output logic                         m_start,
   output logic [I2C_ADDR_W-1:0]        m_addr,
   output logic [I2C_DATA_W-1:0]        m_data,
   input  logic                         m_done
);

   localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_err
      $error("i2c_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   arb_state_e              state_q, state_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    m_start_q, m_start_d;
   logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [I2C_DATA_W-1:0]   m_data_q, m_data_d;
   logic [LG_W-1:0]         last_q, last_d;
   logic [NUM_REQ-1:0]      pick_gnt_s;
   logic                    pick_vld_s;
   logic [LG_W-1:0]         win_idx_s;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CNT_W = timeout_w(TIMEOUT_CYCLES);
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_q, err_d;
`endif

   rr_pick #(.N(NUM_REQ), .W(LG_W)) u_rr_pick (
      .req        (req),
      .last_grant (last_q),
      .gnt        (pick_gnt_s),
      .valid      (pick_vld_s)
   );

   // One-hot winner to index; OR-reduce is exact because at most one bit is set.
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_idx_s = win_idx_s | (pick_gnt_s[i] ? LG_W'(i) : LG_W'(0));
      end
   end

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      m_start_d = 1'b0;
      m_addr_d  = m_addr_q;
      m_data_d  = m_data_q;
      last_d    = last_q;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld_s) begin
               state_d   = LAUNCH;
               gnt_d     = pick_gnt_s;
               last_d    = win_idx_s;
               m_start_d = 1'b1;
               m_addr_d  = req_addr[I2C_ADDR_W*int'(win_idx_s) +: I2C_ADDR_W];
               m_data_d  = req_data[I2C_DATA_W*int'(win_idx_s) +: I2C_DATA_W];
`ifdef I2C_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (m_done) begin
               state_d = FINISH;
               done_d  = gnt_q;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            // Abort as the count would reach TIMEOUT_CYCLES-1; m_done above has priority.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
               state_d = IDLE;
               gnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`else
            else begin
               state_d = WAIT;
            end
`endif
         end
         FINISH: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         m_start_q <= 1'b0;
         m_addr_q  <= '0;
         m_data_q  <= '0;
         last_q    <= LG_W'(NUM_REQ - 1);
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         m_start_q <= m_start_d;
         m_addr_q  <= m_addr_d;
         m_data_q  <= m_data_d;
         last_q    <= last_d;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   // Watchdog counter and abort pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign m_start = m_start_q;
   assign m_addr  = m_addr_q;
   assign m_data  = m_data_q;

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one I2C byte-write master engine between NUM_REQ requesters.
- Each requester presents a 7-bit slave address and an 8-bit data byte. The arbiter grants one requester, latches its command and pulses the engine's start input.
- It then waits for engine completion and returns a one-cycle done pulse to the winner.
- It sits between on-chip clients (sensor config, LED driver, etc.) and the I2C master that drives sda/scl.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles for one transfer (only used with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_addr  input  7*NUM_REQ  packed slave addresses; requester i uses bits [7i+6:7i].
- req_data  input  8*NUM_REQ  packed data bytes; requester i uses bits [8i+7:8i].
- gnt  output  NUM_REQ  one-hot grant, held for the whole transfer.
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle watchdog-abort pulse; constant 0 when the feature is compiled out.
- busy  output  1  high whenever state is not IDLE.
- m_start  output  1  one-cycle start pulse to the I2C master.
- m_addr  output  7  latched slave address to the master.
- m_data  output  8  latched data byte to the master.
- m_done  input  1  one-cycle completion pulse from the master.

Behaviour:
- All outputs are registered.
- Reset values:
  - gnt=0, done=0, err=0, busy=0, m_start=0, m_addr=0, m_data=0.
  - State=IDLE.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - If any req bit is set, pick the winner w as the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - On the clock edge: latch req_addr[w] into m_addr and req_data[w] into m_data, set gnt to one-hot w, set last_grant=w, go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH: m_start=1 for exactly this cycle; m_done is ignored here; next state WAIT.
- WAIT:
  - m_start=0; hold gnt, m_addr and m_data stable.
  - On a sampled m_done=1, go to FINISH.
- FINISH:
  - done[w]=1 for exactly one cycle; gnt stays asserted this cycle.
  - Next state IDLE with gnt=0.
- Latency:
  - A req seen in IDLE at cycle T gives gnt and m_start high during T+1.
  - m_done at cycle D gives done[w] high during D+1, then gnt low at D+2.
- Fairness:
  - A requester that holds req after done is re-arbitrated behind any other pending requester.
  - No requester waits more than NUM_REQ-1 transfers.
- Requests arriving during LAUNCH, WAIT or FINISH are not sampled until IDLE.
- req_addr and req_data of the winner only need to be valid in the IDLE cycle where it wins; later changes are ignored.
- Dropping req mid-transfer does not abort the transfer; done is still pulsed.
- Simultaneous requests: the round-robin order alone decides; with last_grant=1 and req=4'b1011, the winner is 3.
- m_done seen in IDLE or LAUNCH is ignored; no spurious done pulse is produced.
- Reset asserted mid-transfer returns everything to reset values on the next edge, with no done pulse. The master engine is expected to be reset by the same rst.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to LAUNCH and increments every cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without m_done, go to IDLE with gnt=0, pulse err for one cycle and give no done pulse.
  - last_grant keeps its updated value, so the hung requester loses priority.
  - If m_done arrives in the same cycle as the limit, m_done wins.
- Not defined: no counter exists, WAIT waits indefinitely, and err is tied to 0.

Decomposition:
- Shared package i2c_pkg holds:
  - the I2C_ADDR_W=7 and I2C_DATA_W=8 constants;
  - the arbiter state enum (IDLE, LAUNCH, WAIT, FINISH);
  - a TIMEOUT_W width helper.
- The i2c master should adopt the same width constants from i2c_pkg.
- One sub-module, rr_pick:
  - purely combinational round-robin priority select;
  - inputs: req and last_grant; outputs: one-hot winner and a valid flag.
  - It is reusable by future shared-bus arbiters.

Test Plan:
- Reset, then req=4'b0001 with addr 7'h50 and data 8'hA5 → gnt=0001 and m_start for 1 cycle at T+1, m_addr=50, m_data=A5; m_done 5 cycles later → done[0] 1 cycle later, busy low after.
- Hold req=4'b1111 for 8 transfers → grant order 0,1,2,3,0,1,2,3; exactly one done per transfer; gnt is always one-hot.
- Change req_data[0] from A5 to 3C during WAIT → m_data stays A5 until FINISH.
- Pulse m_done while IDLE, and again during LAUNCH → no done, no state change, no gnt.
- Assert rst for 1 cycle in WAIT with gnt=0100 → next cycle gnt=0, busy=0, m_start=0, no done; the next req=4'b0001 is granted normally.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold m_done → err pulses once 16 cycles after LAUNCH, gnt clears, no done; without the macro → still busy after 1000 cycles.
